interval_timer: RTL

Initiator side of the time-parameter lookup in the traffic-light controller.
- Takes a timing request (interval code) from the main light FSM and drives that code onto the time-parameter store's interval input.
- Captures the returned 4-bit second count, then counts it down on the 1 Hz enable.
- Signals the FSM with a one-cycle expired pulse.
- Aborts cleanly when the parameter store is reprogrammed (prog_sync).

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/interval_timer_if.sv | 35 +++
 rtl/interval_timer_down_counter.sv | 46 ++++
 rtl/interval_timer.sv | 117 +++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared definitions for the traffic-light controller timing path.
//            Holds the interval codes, the interval-timer state encoding and
//            the default widths of the time-parameter bus.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

   localparam int VAL_W_DEF = 4;
   localparam int SEL_W_DEF = 2;

   localparam logic [1:0] INT_TBASE = 2'b00;
   localparam logic [1:0] INT_TEXT  = 2'b01;
   localparam logic [1:0] INT_TYEL  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_COUNT = 2'd2
   } timer_state_t;

endpackage
`default_nettype wire

// File: rtl/interval_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer_if
// Purpose  : Bundle between the light FSM / parameter store (master side) and
//            the interval timer (slave side).
// Signals  : start_timer, interval_req, one_hz_enable, prog_sync, value
//            (master -> timer); interval, expired, busy, remaining
//            (timer -> master).
// Revision : 1.0 - initial release
// ============================================================================
interface interval_timer_if #(
   parameter int VAL_W = 4,
   parameter int SEL_W = 2
);
   logic             start_timer;
   logic [SEL_W-1:0] interval_req;
   logic             one_hz_enable;
   logic             prog_sync;
   logic [VAL_W-1:0] value;
   logic [SEL_W-1:0] interval;
   logic             expired;
   logic             busy;
   logic [VAL_W-1:0] remaining;

   modport master (
      output start_timer, interval_req, one_hz_enable, prog_sync, value,
      input  interval, expired, busy, remaining
   );

   modport slave (
      input  start_timer, interval_req, one_hz_enable, prog_sync, value,
      output interval, expired, busy, remaining
   );
endinterface
`default_nettype wire

// File: rtl/interval_timer_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : down_counter
// Purpose  : Loadable down-counter. Clear has priority over load, load over
//            decrement. Decrement is gated by i_dec_en and saturates at 0.
// Ports    : clk, rst        - clock, async active-high reset
//            i_clear         - force count to 0
//            i_load/i_load_val - load a new count
//            i_dec_en        - decrement by one (no effect at 0)
//            o_count         - current count
//            o_tc            - terminal count (count == 1)
//            o_zero          - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module down_counter #(
   parameter int VAL_W = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_clear,
   input  wire logic             i_load,
   input  wire logic [VAL_W-1:0] i_load_val,
   input  wire logic             i_dec_en,
   output logic      [VAL_W-1:0] o_count,
   output logic                  o_tc,
   output logic                  o_zero
);
   logic [VAL_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec_en && (r_count != '0)) begin
         r_count <= r_count - VAL_W'(1);
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == VAL_W'(1));
   assign o_zero  = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : interval_timer
// Purpose  : Requests a time value from the parameter store by presenting an
//            interval code, loads the returned second count after one settle
//            cycle and counts it down on the 1 Hz tick, then pulses expired.
//            Reprogramming of the store (prog_sync) aborts silently.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-high reset
//            bus   - interval_timer_if.slave (request, tick, abort, value in;
//                    interval, expired, busy, remaining out)
// Revision : 1.0 - initial release
// ============================================================================
module interval_timer
   import traffic_pkg::*;
#(
   parameter int VAL_W = VAL_W_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input wire logic         clk,
   input wire logic         reset,
   interval_timer_if.slave  bus
);
   timer_state_t     r_state, w_state_nxt;
   logic [SEL_W-1:0] r_interval, w_interval_nxt;
   logic             r_expired, w_expired_nxt;
   logic             r_zero_pend, w_zero_pend_nxt;
   logic             w_cnt_clear, w_cnt_load, w_cnt_dec;
   logic             w_cnt_tc, w_cnt_zero;
   logic [VAL_W-1:0] w_count;
   logic [SEL_W-1:0] w_mapped;

   // Reserved code falls back to the base interval.
   assign w_mapped = (bus.interval_req == {SEL_W{1'b1}}) ? SEL_W'(INT_TBASE)
                                                         : bus.interval_req;

   down_counter #(.VAL_W(VAL_W)) u_cnt (
      .clk        (clk),
      .rst        (reset),
      .i_clear    (w_cnt_clear),
      .i_load     (w_cnt_load),
      .i_load_val (bus.value),
      .i_dec_en   (w_cnt_dec),
      .o_count    (w_count),
      .o_tc       (w_cnt_tc),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_interval  <= '0;
         r_expired   <= 1'b0;
         r_zero_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_interval  <= w_interval_nxt;
         r_expired   <= w_expired_nxt;
         r_zero_pend <= w_zero_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_interval_nxt  = r_interval;
      w_expired_nxt   = 1'b0;
      w_zero_pend_nxt = 1'b0;
      w_cnt_clear     = 1'b0;
      w_cnt_load      = 1'b0;
      w_cnt_dec       = 1'b0;

      if (bus.prog_sync) begin
         // Abort: interval code is deliberately kept.
         w_state_nxt = ST_IDLE;
         w_cnt_clear = 1'b1;
      end else if (bus.start_timer) begin
         // (Re)start; remaining holds until the LOAD edge.
         w_interval_nxt = w_mapped;
         w_state_nxt    = ST_LOAD;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A zero-valued interval expires one cycle after its LOAD edge.
               w_expired_nxt = r_zero_pend;
            end
            ST_LOAD: begin
               w_cnt_load = 1'b1;
               if (bus.value == '0) begin
                  w_state_nxt     = ST_IDLE;
                  w_zero_pend_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (bus.one_hz_enable) begin
                  w_cnt_dec = 1'b1;
                  // Zero check keeps the FSM from sticking if count is 0.
                  if (w_cnt_tc || w_cnt_zero) begin
                     w_expired_nxt = 1'b1;
                     w_state_nxt   = ST_IDLE;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.interval  = r_interval;
   assign bus.expired   = r_expired;
   assign bus.remaining = w_count;
   assign bus.busy      = (r_state != ST_IDLE);
endmodule
`default_nettype wire
